// File: rtl/uart_cmd_frame_parser.sv
// uart_cmd_frame_parser
// Parses HEADER, func, channel, payload, CRC-8, FOOTER frames from the UART
// byte stream and drives channel config writes and the channel enable register.
// Build option: define ACK_TX_EN to add the 3-byte ack transmitter
// (0x5A, status, 0xA5); otherwise tx_data/tx_valid are tied low.
module uart_cmd_frame_parser #(
   parameter int         NUM_CH        = 4,
   parameter int         PAYLOAD_BYTES = 10,
   parameter logic [7:0] HEADER        = 8'h55,
   parameter logic [7:0] FOOTER        = 8'hAA,
   parameter logic [7:0] CRC_POLY      = 8'h07,
   parameter int         TIMEOUT_CYC   = 50000,
   parameter int         CNT_W         = 8,
   localparam int        CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int        PAY_W         = 8 * PAYLOAD_BYTES
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              cfg_wr,
   output logic [CH_W-1:0]   cfg_ch,
   output logic [PAY_W-1:0]  cfg_payload,
   output logic [NUM_CH-1:0] ch_en,
   output logic              frame_ok,
   output logic              frame_err,
   output logic [2:0]        err_code,
   output logic [CNT_W-1:0]  crc_err_cnt,
   output logic              busy,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam int         TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam int         BCNT_W   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_CRC     = 3'd1;
   localparam logic [2:0] ERR_FOOTER  = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_FUNC    = 3'd4;
   localparam logic [2:0] ERR_CH      = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_FUNC, S_CH, S_PAY, S_CRC, S_FTR, S_EXEC
   } state_e;

   state_e state_q, state_d;

   // Frame capture registers
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]        func_q, func_d;
   logic [7:0]        ch_q, ch_d;
   logic [PAY_W-1:0]  pay_q, pay_d;
   logic [7:0]        crc_q, crc_d;
   logic              crc_ok_q, crc_ok_d;

   // Output registers
   logic              cfg_wr_q, cfg_wr_d;
   logic [CH_W-1:0]   cfg_ch_q, cfg_ch_d;
   logic [PAY_W-1:0]  cfg_payload_q, cfg_payload_d;
   logic [NUM_CH-1:0] ch_en_q, ch_en_d;
   logic              frame_ok_q, frame_ok_d;
   logic              frame_err_q, frame_err_d;
   logic [2:0]        err_code_q, err_code_d;
   logic [CNT_W-1:0]  crc_err_cnt_q, crc_err_cnt_d;

   logic tmo_hit;
   logic byte_in;

   // One CRC-8 step over a full byte, MSB first, no reflection.
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   assign busy    = (state_q != S_IDLE);
   // Timeout wins over a byte arriving in the same cycle; EXEC never times out.
   assign tmo_hit = busy && (state_q != S_EXEC) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));
   assign byte_in = rx_valid && !tmo_hit && (state_q != S_EXEC);

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Next-state: one byte per transition, EXEC lasts a single cycle
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      if (tmo_hit) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (rx_valid && rx_data == HEADER) state_d = S_FUNC;
            S_FUNC: if (rx_valid) state_d = S_CH;
            S_CH:   if (rx_valid) state_d = S_PAY;
            S_PAY:  if (rx_valid && byte_cnt_q == BCNT_W'(PAYLOAD_BYTES - 1)) state_d = S_CRC;
            S_CRC:  if (rx_valid) state_d = S_FTR;
            S_FTR:  if (rx_valid) state_d = S_EXEC;
            S_EXEC: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Frame capture: timeout counter, field registers and running CRC
   always_comb begin
      tmo_cnt_d  = tmo_cnt_q;
      byte_cnt_d = byte_cnt_q;
      func_d     = func_q;
      ch_d       = ch_q;
      pay_d      = pay_q;
      crc_d      = crc_q;
      crc_ok_d   = crc_ok_q;

      if (!busy || state_q == S_EXEC || tmo_hit || rx_valid) begin
         tmo_cnt_d = '0;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end

      if (byte_in) begin
         case (state_q)
            S_IDLE: begin
               crc_d      = 8'h00;
               byte_cnt_d = '0;
            end
            S_FUNC: begin
               func_d = rx_data;
               crc_d  = crc8_next(crc_q, rx_data);
            end
            S_CH: begin
               ch_d       = rx_data;
               crc_d      = crc8_next(crc_q, rx_data);
               byte_cnt_d = '0;
            end
            S_PAY: begin
               pay_d       = pay_q << 8;
               pay_d[7:0]  = rx_data;
               crc_d       = crc8_next(crc_q, rx_data);
               byte_cnt_d  = byte_cnt_q + 1'b1;
            end
            S_CRC: crc_ok_d = (rx_data == crc_q);
            default: ;
         endcase
      end
   end

   // Output decision: classify the frame on the footer byte, or flag a timeout
   always_comb begin
      cfg_wr_d      = 1'b0;
      frame_ok_d    = 1'b0;
      frame_err_d   = 1'b0;
      cfg_ch_d      = cfg_ch_q;
      cfg_payload_d = cfg_payload_q;
      ch_en_d       = ch_en_q;
      err_code_d    = err_code_q;
      crc_err_cnt_d = crc_err_cnt_q;

      if (tmo_hit) begin
         frame_err_d = 1'b1;
         err_code_d  = ERR_TIMEOUT;
      end else if (state_q == S_FTR && rx_valid) begin
         if (rx_data != FOOTER) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_FOOTER;
         end else if (!crc_ok_q) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CRC;
            if (crc_err_cnt_q != '1) crc_err_cnt_d = crc_err_cnt_q + 1'b1;
         end else if (ch_q == 8'd0 || ch_q > NUM_CH_B) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CH;
         end else if (func_q != 8'h01 && func_q != 8'h02) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_FUNC;
         end else begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_NONE;
            if (func_q == 8'h01) begin
               cfg_wr_d      = 1'b1;
               cfg_ch_d      = CH_W'(ch_q - 8'd1);
               cfg_payload_d = pay_q;
            end else begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_q == 8'(i + 1)) ch_en_d[i] = pay_q[PAY_W-8];
               end
            end
         end
      end
   end

   // Datapath and output flops
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tmo_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         func_q        <= '0;
         ch_q          <= '0;
         pay_q         <= '0;
         crc_q         <= '0;
         crc_ok_q      <= 1'b0;
         cfg_wr_q      <= 1'b0;
         cfg_ch_q      <= '0;
         cfg_payload_q <= '0;
         ch_en_q       <= '0;
         frame_ok_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         err_code_q    <= '0;
         crc_err_cnt_q <= '0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         func_q        <= func_d;
         ch_q          <= ch_d;
         pay_q         <= pay_d;
         crc_q         <= crc_d;
         crc_ok_q      <= crc_ok_d;
         cfg_wr_q      <= cfg_wr_d;
         cfg_ch_q      <= cfg_ch_d;
         cfg_payload_q <= cfg_payload_d;
         ch_en_q       <= ch_en_d;
         frame_ok_q    <= frame_ok_d;
         frame_err_q   <= frame_err_d;
         err_code_q    <= err_code_d;
         crc_err_cnt_q <= crc_err_cnt_d;
      end
   end

   assign cfg_wr      = cfg_wr_q;
   assign cfg_ch      = cfg_ch_q;
   assign cfg_payload = cfg_payload_q;
   assign ch_en       = ch_en_q;
   assign frame_ok    = frame_ok_q;
   assign frame_err   = frame_err_q;
   assign err_code    = err_code_q;
   assign crc_err_cnt = crc_err_cnt_q;

`ifdef ACK_TX_EN
   logic       ack_active_q, ack_active_d;
   logic [1:0] ack_idx_q, ack_idx_d;
   logic [2:0] ack_status_q, ack_status_d;

   // Ack sequencer: advance on handshake, start or refresh status on EXEC
   always_comb begin
      ack_active_d = ack_active_q;
      ack_idx_d    = ack_idx_q;
      ack_status_d = ack_status_q;
      if (ack_active_q && tx_ready) begin
         if (ack_idx_q == 2'd2) begin
            ack_active_d = 1'b0;
            ack_idx_d    = 2'd0;
         end else begin
            ack_idx_d = ack_idx_q + 2'd1;
         end
      end
      // The status byte can only be replaced before it is first presented.
      if (state_q == S_EXEC) begin
         if (!ack_active_d) begin
            ack_active_d = 1'b1;
            ack_idx_d    = 2'd0;
            ack_status_d = err_code_q;
         end else if (ack_idx_q == 2'd0) begin
            ack_status_d = err_code_q;
         end
      end
   end

   // Ack sequencer flops
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ack_active_q <= 1'b0;
         ack_idx_q    <= 2'd0;
         ack_status_q <= 3'd0;
      end else begin
         ack_active_q <= ack_active_d;
         ack_idx_q    <= ack_idx_d;
         ack_status_q <= ack_status_d;
      end
   end

   // Ack byte mux; zero when idle
   always_comb begin
      tx_data = 8'h00;
      if (ack_active_q) begin
         case (ack_idx_q)
            2'd0:    tx_data = 8'h5A;
            2'd1:    tx_data = {5'b0, ack_status_q};
            default: tx_data = 8'hA5;
         endcase
      end
   end

   assign tx_valid = ack_active_q;
`else
   logic unused_tx_ready;
   assign unused_tx_ready = tx_ready;
   assign tx_data         = 8'h00;
   assign tx_valid        = 1'b0;
`endif

endmodule
